// File: rtl/order_book_qty.sv
// ----------------------------------------------------------------------------
// order_book_qty
//   Quantity-aware limit order book holding DEPTH resting bids and DEPTH
//   resting asks. A crossed book produces at most one (possibly partial) fill
//   per cycle. An ML-driven circuit breaker can throttle order entry, widen
//   the crossing threshold, or pause the book entirely.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  order handshake; in_side 0=buy 1=sell, in_price, in_qty
//   cb_load         one-cycle pulse latching cb_mode / cb_param
//   match_*         registered one-cycle trade report (price = resting ask)
//   best_bid/ask    top of book (0 / all ones when the side is empty)
//   bid/ask_count   number of valid entries per side
//   cb_active       circuit breaker mode != NORMAL
//   cb_state        current circuit breaker mode
// ----------------------------------------------------------------------------
module order_book_qty #(
    parameter int DEPTH   = 4,
    parameter int PRICE_W = 8,
    parameter int QTY_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic                       in_side,
    input  logic [PRICE_W-1:0]         in_price,
    input  logic [QTY_W-1:0]           in_qty,
    output logic                       in_ready,
    input  logic                       cb_load,
    input  logic [1:0]                 cb_mode,
    input  logic [7:0]                 cb_param,
    output logic                       match_valid,
    output logic [PRICE_W-1:0]         match_price,
    output logic [QTY_W-1:0]           match_qty,
    output logic [PRICE_W-1:0]         best_bid,
    output logic [PRICE_W-1:0]         best_ask,
    output logic [$clog2(DEPTH+1)-1:0] bid_count,
    output logic [$clog2(DEPTH+1)-1:0] ask_count,
    output logic                       cb_active,
    output logic [1:0]                 cb_state
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        CB_NORMAL   = 2'b00,
        CB_THROTTLE = 2'b01,
        CB_WIDEN    = 2'b10,
        CB_PAUSE    = 2'b11
    } cb_mode_e;

    // ------------------------------------------------------------------
    // Book storage
    // ------------------------------------------------------------------
    logic               bid_vld_q   [DEPTH];
    logic [PRICE_W-1:0] bid_price_q [DEPTH];
    logic [QTY_W-1:0]   bid_qty_q   [DEPTH];
    logic               ask_vld_q   [DEPTH];
    logic [PRICE_W-1:0] ask_price_q [DEPTH];
    logic [QTY_W-1:0]   ask_qty_q   [DEPTH];

    logic               bid_vld_d   [DEPTH];
    logic [PRICE_W-1:0] bid_price_d [DEPTH];
    logic [QTY_W-1:0]   bid_qty_d   [DEPTH];
    logic               ask_vld_d   [DEPTH];
    logic [PRICE_W-1:0] ask_price_d [DEPTH];
    logic [QTY_W-1:0]   ask_qty_d   [DEPTH];

    // Circuit breaker state. Only param[7:4] is ever consulted after the load
    // (throttle period and widen guard), so only those bits are kept.
    cb_mode_e           mode_q, mode_d;
    logic [3:0]         param_hi_q, param_hi_d;
    logic [8:0]         cd_q, cd_d;
    logic [3:0]         thr_q, thr_d;

    logic               match_valid_q;
    logic [PRICE_W-1:0] match_price_q;
    logic [QTY_W-1:0]   match_qty_q;

    // ------------------------------------------------------------------
    // Book scan: best price (ties to lowest index), lowest free slot, count
    // ------------------------------------------------------------------
    logic               bid_any, ask_any;
    logic [IDX_W-1:0]   best_bid_idx, best_ask_idx;
    logic [PRICE_W-1:0] best_bid_price, best_ask_price;
    logic               bid_free_ok, ask_free_ok;
    logic [IDX_W-1:0]   bid_free_idx, ask_free_idx;
    logic [CNT_W-1:0]   bid_cnt, ask_cnt;

    always_comb begin
        bid_any        = 1'b0;
        best_bid_idx   = '0;
        best_bid_price = '0;
        bid_free_ok    = 1'b0;
        bid_free_idx   = '0;
        bid_cnt        = '0;
        ask_any        = 1'b0;
        best_ask_idx   = '0;
        best_ask_price = '1;
        ask_free_ok    = 1'b0;
        ask_free_idx   = '0;
        ask_cnt        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bid_vld_q[i]) begin
                bid_cnt = bid_cnt + CNT_W'(1);
                // Strict compare keeps the earlier (lower) index on ties.
                if (!bid_any || (bid_price_q[i] > best_bid_price)) begin
                    bid_any        = 1'b1;
                    best_bid_idx   = IDX_W'(i);
                    best_bid_price = bid_price_q[i];
                end
            end else if (!bid_free_ok) begin
                bid_free_ok  = 1'b1;
                bid_free_idx = IDX_W'(i);
            end
            if (ask_vld_q[i]) begin
                ask_cnt = ask_cnt + CNT_W'(1);
                if (!ask_any || (ask_price_q[i] < best_ask_price)) begin
                    ask_any        = 1'b1;
                    best_ask_idx   = IDX_W'(i);
                    best_ask_price = ask_price_q[i];
                end
            end else if (!ask_free_ok) begin
                ask_free_ok  = 1'b1;
                ask_free_idx = IDX_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Order gate and acceptance
    // ------------------------------------------------------------------
    logic order_gate;
    logic accept;
    logic store_bid, store_ask;

    always_comb begin
        order_gate = 1'b1;
        case (mode_q)
            CB_PAUSE:    order_gate = 1'b0;
            CB_THROTTLE: order_gate = (thr_q == 4'd0);
            default:     order_gate = 1'b1;
        endcase
    end

    assign in_ready  = order_gate & (in_side ? ask_free_ok : bid_free_ok);
    assign accept    = in_valid & in_ready;
    // Zero-quantity orders complete the handshake but never occupy a slot.
    assign store_bid = accept & ~in_side & (in_qty != '0);
    assign store_ask = accept &  in_side & (in_qty != '0);

    // ------------------------------------------------------------------
    // Matching
    // ------------------------------------------------------------------
    logic [2:0]         guard;
    logic [PRICE_W:0]   ask_plus_guard;
    logic               crossing;
    logic               do_match;
    logic [QTY_W-1:0]   bid_top_qty, ask_top_qty, fill;

    assign guard          = (mode_q == CB_WIDEN) ? param_hi_q[3:1] : 3'd0;
    // One extra bit so an ask near all-ones plus the guard cannot wrap.
    assign ask_plus_guard = {1'b0, best_ask_price} + {{(PRICE_W-2){1'b0}}, guard};
    assign crossing       = bid_any & ask_any & ({1'b0, best_bid_price} >= ask_plus_guard);
    assign do_match       = crossing & (mode_q != CB_PAUSE);
    assign bid_top_qty    = bid_qty_q[best_bid_idx];
    assign ask_top_qty    = ask_qty_q[best_ask_idx];
    assign fill           = (bid_top_qty < ask_top_qty) ? bid_top_qty : ask_top_qty;

    // ------------------------------------------------------------------
    // Per-entry next state. The write target is always an invalid slot and
    // the debited entry is always valid, so the two never collide.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic             bid_wr, bid_hit, ask_wr, ask_hit;
            logic [QTY_W-1:0] bid_rem, ask_rem;

            assign bid_wr  = store_bid & (bid_free_idx == IDX_W'(gi));
            assign bid_hit = do_match & (best_bid_idx == IDX_W'(gi));
            assign bid_rem = bid_qty_q[gi] - fill;
            assign ask_wr  = store_ask & (ask_free_idx == IDX_W'(gi));
            assign ask_hit = do_match & (best_ask_idx == IDX_W'(gi));
            assign ask_rem = ask_qty_q[gi] - fill;

            assign bid_vld_d[gi]   = bid_wr | (bid_vld_q[gi] & ~(bid_hit & (bid_rem == '0)));
            assign bid_price_d[gi] = bid_wr ? in_price : bid_price_q[gi];
            assign bid_qty_d[gi]   = bid_wr ? in_qty : (bid_hit ? bid_rem : bid_qty_q[gi]);
            assign ask_vld_d[gi]   = ask_wr | (ask_vld_q[gi] & ~(ask_hit & (ask_rem == '0)));
            assign ask_price_d[gi] = ask_wr ? in_price : ask_price_q[gi];
            assign ask_qty_d[gi]   = ask_wr ? in_qty : (ask_hit ? ask_rem : ask_qty_q[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bid_vld_q[i]   <= 1'b0;
                bid_price_q[i] <= '0;
                bid_qty_q[i]   <= '0;
                ask_vld_q[i]   <= 1'b0;
                ask_price_q[i] <= '0;
                ask_qty_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                bid_vld_q[i]   <= bid_vld_d[i];
                bid_price_q[i] <= bid_price_d[i];
                bid_qty_q[i]   <= bid_qty_d[i];
                ask_vld_q[i]   <= ask_vld_d[i];
                ask_price_q[i] <= ask_price_d[i];
                ask_qty_q[i]   <= ask_qty_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Trade report: pulse on match, price/qty hold between trades
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_valid_q <= 1'b0;
            match_price_q <= '0;
            match_qty_q   <= '0;
        end else begin
            match_valid_q <= do_match;
            if (do_match) begin
                match_price_q <= best_ask_price;
                match_qty_q   <= fill;
            end
        end
    end

    // ------------------------------------------------------------------
    // Circuit breaker: a load always wins; otherwise an active mode counts
    // down and falls back to NORMAL one cycle after reaching zero.
    // ------------------------------------------------------------------
    always_comb begin
        mode_d     = mode_q;
        param_hi_d = param_hi_q;
        cd_d       = cd_q;
        thr_d      = 4'd0;
        if (cb_load) begin
            mode_d     = cb_mode_e'(cb_mode);
            param_hi_d = cb_param[7:4];
            case (cb_mode_e'(cb_mode))
                CB_NORMAL: cd_d = 9'd0;
                CB_PAUSE:  cd_d = {cb_param, 1'b0};
                default:   cd_d = {1'b0, cb_param};
            endcase
        end else begin
            if (mode_q != CB_NORMAL) begin
                if (cd_q == 9'd0) begin
                    mode_d = CB_NORMAL;
                end else begin
                    cd_d = cd_q - 9'd1;
                end
            end
            // Throttle opens the gate once every param_hi+1 cycles.
            if (mode_q == CB_THROTTLE) begin
                thr_d = (thr_q == param_hi_q) ? 4'd0 : thr_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= CB_NORMAL;
            param_hi_q <= 4'd0;
            cd_q       <= 9'd0;
            thr_q      <= 4'd0;
        end else begin
            mode_q     <= mode_d;
            param_hi_q <= param_hi_d;
            cd_q       <= cd_d;
            thr_q      <= thr_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign match_valid = match_valid_q;
    assign match_price = match_price_q;
    assign match_qty   = match_qty_q;
    assign best_bid    = best_bid_price;
    assign best_ask    = best_ask_price;
    assign bid_count   = bid_cnt;
    assign ask_count   = ask_cnt;
    assign cb_active   = (mode_q != CB_NORMAL);
    assign cb_state    = mode_q;

endmodule
